// File: rtl/sar_search.sv
// Successive-approximation search driving an external comparator, one probe per clock.
// Optional SAR_SEARCH_ITER_EN adds an iter_count output with the probe count of the last search.
module sar_search #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [W-1:0] trial,
    input  logic         cmp_less,
    input  logic         cmp_equal,
    input  logic         cmp_greater,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         err,
    output logic [W-1:0] result
`ifdef SAR_SEARCH_ITER_EN
    ,
    output logic [W:0]   iter_count
`endif
);

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    localparam logic [W:0]   HI_INIT    = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0] TRIAL_INIT = W'(HI_INIT >> 1);

    state_t     state;
    logic [W:0] lo;
    logic [W:0] hi;

    // Average of two W+1-bit bounds; the sum is widened so it never wraps.
    function automatic logic [W-1:0] midpoint(input logic [W:0] a, input logic [W:0] b);
        return W'(({1'b0, a} + {1'b0, b}) >> 1);
    endfunction

    function automatic logic is_one_hot(input logic l, input logic e, input logic g);
        return ({l, e, g} == 3'b001) || ({l, e, g} == 3'b010) || ({l, e, g} == 3'b100);
    endfunction

    logic [W:0] trial_ext;
    logic [W:0] lo_up;
    logic [W:0] hi_dn;

    assign trial_ext = {1'b0, trial};
    assign lo_up     = trial_ext + 1'b1;
    assign hi_dn     = trial_ext - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            trial  <= '0;
            result <= '0;
            lo     <= '0;
            hi     <= HI_INIT;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
`ifdef SAR_SEARCH_ITER_EN
            iter_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PROBE;
                        lo    <= '0;
                        hi    <= HI_INIT;
                        trial <= TRIAL_INIT;
                        found <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
`ifdef SAR_SEARCH_ITER_EN
                        iter_count <= '0;
`endif
                    end
                end

                PROBE: begin
`ifdef SAR_SEARCH_ITER_EN
                    iter_count <= iter_count + 1'b1;
`endif
                    // Any exit from PROBE captures the current trial and raises done.
                    if (!is_one_hot(cmp_less, cmp_equal, cmp_greater)) begin
                        result <= trial;
                        err    <= 1'b1;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (cmp_equal) begin
                        result <= trial;
                        found  <= 1'b1;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (cmp_greater && (trial_ext < hi)) begin
                        lo    <= lo_up;
                        trial <= midpoint(lo_up, hi);
                    end else if (cmp_less && (trial_ext > lo)) begin
                        hi    <= hi_dn;
                        trial <= midpoint(lo, hi_dn);
                    end else begin
                        // Interval exhausted: x is not in range.
                        result <= trial;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (W=3) with a behavioural comparator around a hidden value x.
module tb_sar_search;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] trial;
    logic         cmp_less;
    logic         cmp_equal;
    logic         cmp_greater;
    logic         busy;
    logic         done;
    logic         found;
    logic         err;
    logic [W-1:0] result;
`ifdef SAR_SEARCH_ITER_EN
    logic [W:0]   iter_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // mode 0: ideal comparator on x; 1: greater only; 2: less and greater together
    int           mode;
    logic [W-1:0] x;

    assign cmp_less    = (mode == 0) ? (x < trial) : (mode == 2);
    assign cmp_equal   = (mode == 0) ? (x == trial) : 1'b0;
    assign cmp_greater = (mode == 0) ? (x > trial) : 1'b1;

    sar_search #(.W(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .trial(trial),
        .cmp_less(cmp_less),
        .cmp_equal(cmp_equal),
        .cmp_greater(cmp_greater),
        .busy(busy),
        .done(done),
        .found(found),
        .err(err),
        .result(result)
`ifdef SAR_SEARCH_ITER_EN
        ,
        .iter_count(iter_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start a search and follow it through every probe to the done pulse.
    task automatic search(input string tag, input int md, input logic [W-1:0] xv, input int ntr,
                          input logic [3:0][3:0] trs, input logic exp_found,
                          input logic exp_err, input logic [W-1:0] exp_result);
        mode  = md;
        x     = xv;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < ntr; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_trial"}, 32'(trial), 32'(trs[i][W-1:0]));
            step();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_found"}, 32'(found), 32'(exp_found));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_result"}, 32'(result), 32'(exp_result));
`ifdef SAR_SEARCH_ITER_EN
        check({tag, "_iter"}, 32'(iter_count), 32'(ntr));
`endif
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_result_hold"}, 32'(result), 32'(exp_result));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 0;
        x     = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_trial", 32'(trial), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        check("idle_hold_busy", 32'(busy), 32'd0);
        check("idle_hold_trial", 32'(trial), 32'd0);

        search("x5", 0, 3'd5, 2, {4'd0, 4'd0, 4'd5, 4'd3}, 1'b1, 1'b0, 3'd5);
        search("x7", 0, 3'd7, 4, {4'd7, 4'd6, 4'd5, 4'd3}, 1'b1, 1'b0, 3'd7);
        search("x0", 0, 3'd0, 3, {4'd0, 4'd0, 4'd1, 4'd3}, 1'b1, 1'b0, 3'd0);
        search("x2", 0, 3'd2, 3, {4'd0, 4'd2, 4'd1, 4'd3}, 1'b1, 1'b0, 3'd2);
        search("grt", 1, 3'd0, 4, {4'd7, 4'd6, 4'd5, 4'd3}, 1'b0, 1'b0, 3'd7);
        search("both", 2, 3'd0, 1, {4'd0, 4'd0, 4'd0, 4'd3}, 1'b0, 1'b1, 3'd3);

        // Reset during the second probe of x=5.
        mode  = 0;
        x     = 3'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("rr_trial2", 32'(trial), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_state_busy", 32'(busy), 32'd0);
        check("rr_trial", 32'(trial), 32'd0);
        check("rr_result", 32'(result), 32'd0);
        check("rr_done", 32'(done), 32'd0);
        check("rr_found", 32'(found), 32'd0);
        check("rr_err", 32'(err), 32'd0);
        step();
        search("rr_x5", 0, 3'd5, 2, {4'd0, 4'd0, 4'd5, 4'd3}, 1'b1, 1'b0, 3'd5);

        // Start held high throughout.
        x     = 3'd5;
        start = 1'b1;
        step();
        check("hold_t0", 32'(trial), 32'd3);
        step();
        check("hold_t1", 32'(trial), 32'd5);
        check("hold_busy1", 32'(busy), 32'd1);
        step();
        check("hold_done", 32'(done), 32'd1);
        check("hold_result", 32'(result), 32'd5);
        step();
        check("hold_idle_busy", 32'(busy), 32'd0);
        check("hold_idle_done", 32'(done), 32'd0);
        step();
        check("hold_restart_busy", 32'(busy), 32'd1);
        check("hold_restart_trial", 32'(trial), 32'd3);
        check("hold_restart_found", 32'(found), 32'd0);
        start = 1'b0;
        step();
        step();
        check("hold_done2", 32'(done), 32'd1);
        check("hold_found2", 32'(found), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
